// File: rtl/zmips_dbus_ctrl_if.sv
// Data-bus handshake bundle between the zmips CPU MEM stage, the bus
// controller and the external data bus. The controller uses the master view;
// the CPU/bus environment (or a bench) uses the slave view.
interface zmips_dbus_ctrl_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        err_clr;
  logic        err_flag;
  logic [15:0] txn_count;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  bus_ack, bus_rdata, bus_err, err_clr,
    output cpu_rdata, cpu_stall,
    output bus_req, bus_we, bus_addr, bus_wdata,
    output err_flag, txn_count
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output bus_ack, bus_rdata, bus_err, err_clr,
    input  cpu_rdata, cpu_stall,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    input  err_flag, txn_count
  );
endinterface

// File: rtl/zmips_dbus_ctrl.sv
// zmips data-bus controller: turns CPU load/store strobes into single bus
// accesses, stalls the pipeline while the access is outstanding, aborts
// accesses that see no ack within TIMEOUT cycles and keeps a sticky error
// flag plus a completed-transaction counter. All state moves on the falling
// clock edge so that it lines up with the CPU pipeline registers.
//
// state | meaning
// IDLE  | waiting for a strobe; stall follows the strobe combinationally
// REQ   | bus_req high, address/data/we held, waiting for ack or timeout
// DONE  | one-cycle completion slot, stall released, strobes ignored
module zmips_dbus_ctrl #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input logic                clk,
  input logic                rst,
  zmips_dbus_ctrl_if.master  dbus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic [15:0] txn_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic        err_q;

  logic        in_idle;
  logic        in_req;
  logic        strobe;
  logic        aligned;
  logic        issue;
  logic        misalign;
  logic        ack_hit;
  logic        tmo_hit;
  logic        err_set;

  assign in_idle  = (state == S_IDLE);
  assign in_req   = (state == S_REQ);
  assign strobe   = dbus.cpu_rd | dbus.cpu_wr;
  assign aligned  = (dbus.cpu_addr[1:0] == 2'b00);
  assign issue    = in_idle & strobe & aligned;
  assign misalign = in_idle & strobe & ~aligned;
  assign ack_hit  = in_req & dbus.bus_ack;
  // An ack on the timeout edge wins, so the timeout term is qualified by ~ack.
  assign tmo_hit  = in_req & ~dbus.bus_ack &
                    (({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT));

  // Error sources: misaligned strobe, rd+wr together, bus error on ack, timeout.
  assign err_set  = misalign
                  | (in_idle & dbus.cpu_rd & dbus.cpu_wr)
                  | (ack_hit & dbus.bus_err)
                  | tmo_hit;

  assign dbus.cpu_stall = (in_idle & strobe) | in_req;
  assign dbus.bus_req   = in_req;
  assign dbus.bus_we    = we_q;
  assign dbus.bus_addr  = addr_q;
  assign dbus.bus_wdata = wdata_q;
  assign dbus.cpu_rdata = rdata_q;
  assign dbus.err_flag  = err_q;
  assign dbus.txn_count = txn_cnt;

  // Sequencer state and the per-access wait counter.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= 16'd0;
          if (issue)         state <= S_REQ;
          else if (misalign) state <= S_DONE;
        end
        S_REQ: begin
          if (ack_hit || tmo_hit) state <= S_DONE;
          else                    wait_cnt <= wait_cnt + 16'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus address/data/direction, captured once at issue and held through REQ.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else if (issue) begin
      addr_q  <= dbus.cpu_addr;
      wdata_q <= dbus.cpu_wdata;
      we_q    <= dbus.cpu_wr;
    end
  end

  // Load data returned to the CPU; only read completions and misaligned
  // strobes change it, stores leave it alone.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (misalign) begin
      rdata_q <= 32'd0;
    end else if (ack_hit && !we_q) begin
      rdata_q <= dbus.bus_rdata;
    end else if (tmo_hit && !we_q) begin
      rdata_q <= ERR_RDATA;
    end
  end

  // Completed-transaction counter; timeouts are not completions.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)          txn_cnt <= 16'd0;
    else if (ack_hit) txn_cnt <= txn_cnt + 16'd1;
  end

  // Sticky error flag; a new error on the clear edge keeps it set.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)               err_q <= 1'b0;
    else if (err_set)      err_q <= 1'b1;
    else if (dbus.err_clr) err_q <= 1'b0;
  end

endmodule

// File: doc/zmips_dbus_ctrl.md
ZMIPS_DBUS_CTRL -- requirements
Module: zmips_dbus_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: number of REQ-state cycles without bus_ack before the controller aborts the access.
REQ-002 Parameter ERR_RDATA, default 32'hDEADBEEF: read data returned to the CPU on a timed-out read.
REQ-003 Port clk, input, 1: single clock; all state updates on negedge clk, matching the CPU pipeline.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port cpu_addr, input, 32: data address from the CPU MEM stage.
REQ-006 Port cpu_wdata, input, 32: store data from the CPU.
REQ-007 Port cpu_rd, input, 1: load strobe.
REQ-008 Port cpu_wr, input, 1: store strobe.
REQ-009 Port cpu_rdata, output, 32: load data returned to the CPU.
REQ-010 Port cpu_stall, output, 1: freeze request to the CPU pipeline.
REQ-011 Port bus_req, output, 1: external bus request.
REQ-012 Port bus_we, output, 1: 1 = write, 0 = read.
REQ-013 Port bus_addr, output, 32: bus address.
REQ-014 Port bus_wdata, output, 32: bus write data.
REQ-015 Port bus_ack, input, 1: bus completion.
REQ-016 Port bus_rdata, input, 32: bus read data, valid with bus_ack.
REQ-017 Port bus_err, input, 1: bus error, valid with bus_ack.
REQ-018 Port err_clr, input, 1: clears err_flag.
REQ-019 Port err_flag, output, 1: sticky error indicator.
REQ-020 Port txn_count, output, 16: count of completed bus transactions.

Function
REQ-021 The state machine SHALL have states IDLE, REQ and DONE; after reset it is in IDLE.
REQ-022 In IDLE with cpu_rd or cpu_wr high and cpu_addr[1:0]==0, the block SHALL latch the address, write data and bus_we (= cpu_wr) and move to REQ.
REQ-023 cpu_stall SHALL be combinational and equal to (IDLE and (cpu_rd or cpu_wr)) or REQ, so the CPU stalls in the same cycle the strobe appears.
REQ-024 If cpu_rd and cpu_wr are both high, the access SHALL be performed as a write and err_flag SHALL be set.
REQ-025 A misaligned access (cpu_addr[1:0]!=0) SHALL NOT raise bus_req; the block SHALL set err_flag, load cpu_rdata with 0, and go directly to DONE.
REQ-026 In REQ, bus_req SHALL be 1, and bus_addr, bus_wdata and bus_we SHALL hold their latched values until the exit edge.
- Outside REQ, bus_req SHALL be 0.
REQ-027 In REQ, bus_ack sampled high SHALL:
- move the state to DONE;
- on a read, capture bus_rdata into cpu_rdata;
- increment txn_count, mod 2^16 (wraps 16'hFFFF -> 0);
- set err_flag if bus_err is high.
REQ-028 A 16-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack. When it reaches TIMEOUT, the block SHALL:
- go to DONE;
- set err_flag;
- on a read, load cpu_rdata with ERR_RDATA;
- leave txn_count unchanged.
REQ-029 bus_ack arriving on the same edge as the timeout SHALL be treated as a normal completion.
REQ-030 DONE SHALL last exactly one cycle with cpu_stall=0, then return to IDLE. A strobe still high in DONE SHALL NOT start a new access.
REQ-031 cpu_rdata SHALL hold its value until the next read completion; writes SHALL NOT alter it.
REQ-032 Minimum access latency SHALL be 3 cycles: issue, ack, DONE; cpu_stall is high for 2 of them.
REQ-033 err_flag SHALL clear when err_clr is high, unless a new error event occurs on the same edge; the set takes priority.
REQ-034 bus_ack outside REQ SHALL be ignored.

Reset
REQ-035 While rst is high, the following SHALL hold immediately, independent of clk:
- state=IDLE, bus_req=0, bus_we=0;
- bus_addr=0, bus_wdata=0;
- cpu_rdata=0, err_flag=0, txn_count=0, wait counter=0.
- cpu_stall then follows REQ-023 from IDLE.
REQ-036 Reset asserted in REQ SHALL abort the access, drop bus_req asynchronously, and leave no pending access after release.

Verification
REQ-037 Read of 0x100 with bus_ack on the 2nd REQ cycle and bus_rdata=0x12345678 -> cpu_rdata=0x12345678, cpu_stall high for 3 cycles, txn_count=1.
REQ-038 Write of 0xCAFEF00D to 0x204 with immediate ack -> bus_we=1, bus_addr=0x204, bus_wdata=0xCAFEF00D held until ack; err_flag=0.
REQ-039 Read with TIMEOUT=4 and no ack -> DONE after 4 REQ cycles, cpu_rdata=0xDEADBEEF, err_flag=1, txn_count unchanged; then err_clr -> err_flag=0.
REQ-040 Read of 0x102 (misaligned) -> bus_req never asserted, cpu_rdata=0, err_flag=1; also cpu_rd and cpu_wr both high -> write performed and err_flag=1.
REQ-041 Preload txn_count to 0xFFFF via 65535 accesses, then one more access -> 0x0000; rst pulsed mid-REQ -> bus_req=0 immediately, state IDLE.
